// File: rtl/mem_bus_ctrl.sv
// Memory-hold responder: services MEM-stage data accesses and IF-stage fetches on one async SRAM.
// Optional one-entry fetch buffer enabled by defining MEM_BUS_IFETCH_BUF_EN.
module mem_bus_ctrl #(
  parameter int                ADDR_W   = 18,
  parameter int                DATA_W   = 16,
  parameter int                WAIT_CYC = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = 16'h0800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_op,
  input  logic              mem_we,
  input  logic [15:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  input  logic              if_req,
  input  logic [15:0]       if_addr,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  typedef enum logic [2:0] {IDLE, D_ACC, D_DONE, F_ACC, F_DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [15:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              acc_last;
  logic              data_drive;

`ifdef MEM_BUS_IFETCH_BUF_EN
  logic              hit_q, hit_d;
  logic              buf_valid_q, buf_valid_d;
  logic [15:0]       buf_tag_q, buf_tag_d;
  logic [DATA_W-1:0] buf_word_q, buf_word_d;
`endif

  assign acc_last = (cnt_q == 3'(WAIT_CYC));

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    inst_d  = inst_q;
`ifdef MEM_BUS_IFETCH_BUF_EN
    hit_d       = 1'b0;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_word_d  = buf_word_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          addr_d  = mem_addr;
          we_d    = mem_we;
          wdata_d = mem_wdata;
          state_d = D_ACC;
        end else if (if_req) begin
`ifdef MEM_BUS_IFETCH_BUF_EN
          if (buf_valid_q && (if_addr == buf_tag_q)) begin
            hit_d  = 1'b1;
            inst_d = buf_word_q;
          end else begin
            addr_d  = if_addr;
            state_d = F_ACC;
          end
`else
          addr_d  = if_addr;
          state_d = F_ACC;
`endif
        end
      end
      D_ACC: begin
        if (acc_last) begin
          if (!we_q) rdata_d = ram_data;
          state_d = D_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      D_DONE: begin
        state_d = IDLE;
`ifdef MEM_BUS_IFETCH_BUF_EN
        if (we_q && (addr_q == buf_tag_q)) buf_valid_d = 1'b0;
`endif
      end
      F_ACC: begin
        if (acc_last) begin
          inst_d  = ram_data;
          state_d = F_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      F_DONE: begin
        state_d = IDLE;
`ifdef MEM_BUS_IFETCH_BUF_EN
        buf_valid_d = 1'b1;
        buf_tag_d   = addr_q;
        buf_word_d  = inst_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      inst_q  <= NOP_WORD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      inst_q  <= inst_d;
    end
  end

`ifdef MEM_BUS_IFETCH_BUF_EN
  // NOTE: only the valid bit needs reset; tag and word are never used while valid is clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_q       <= 1'b0;
      buf_valid_q <= 1'b0;
    end else begin
      hit_q       <= hit_d;
      buf_valid_q <= buf_valid_d;
    end
    buf_tag_q  <= buf_tag_d;
    buf_word_q <= buf_word_d;
  end

  assign inst_valid = (state_q == F_DONE) || hit_q;
`else
  assign inst_valid = (state_q == F_DONE);
`endif

  // Write data stays on the bus through D_DONE to give the SRAM hold time after we_n rises.
  assign data_drive = we_q && ((state_q == D_ACC) || (state_q == D_DONE));
  assign ram_data   = data_drive ? wdata_q : {DATA_W{1'bz}};
  assign ram_addr   = ADDR_W'(addr_q);
  assign ram_ce_n   = !((state_q == D_ACC) || (state_q == F_ACC));
  assign ram_oe_n   = !((state_q == F_ACC) || ((state_q == D_ACC) && !we_q));
  assign ram_we_n   = !((state_q == D_ACC) && we_q);
  assign mem_done   = (state_q == D_DONE);
  assign mem_rdata  = rdata_q;
  assign inst       = inst_valid ? inst_q : NOP_WORD;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomised scoreboard bench for mem_bus_ctrl with an SRAM model and a transaction-level reference.
module tb_mem_bus_ctrl;
  localparam int WAIT_CYC = 1;
  localparam int LAT      = 2 + WAIT_CYC;
`ifdef MEM_BUS_IFETCH_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_op = 1'b0, mem_we = 1'b0, if_req = 1'b0;
  logic [15:0] mem_addr = '0, mem_wdata = '0, if_addr = '0;
  logic [15:0] mem_rdata, inst;
  logic        mem_done, inst_valid, ram_ce_n, ram_oe_n, ram_we_n;
  logic [17:0] ram_addr;
  wire  [15:0] ram_data;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_ctrl #(.ADDR_W(18), .DATA_W(16), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst(rst),
    .mem_op(mem_op), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .if_req(if_req), .if_addr(if_addr), .inst(inst), .inst_valid(inst_valid),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  // SRAM model: 256 words, undriven bus floats high.
  for (genvar g = 0; g < 16; g++) begin : g_pull
    pullup pu (ram_data[g]);
  end

  function automatic logic [15:0] init_word(input int a);
    return (a == 'h40) ? 16'h1234 : 16'(a * 16'h0107) ^ 16'h5A00;
  endfunction

  logic [15:0] sram [0:255];
  logic        sram_init = 1'b0;
  always @(posedge clk) begin
    if (!sram_init) begin
      for (int i = 0; i < 256; i++) sram[i] <= init_word(i);
      sram_init <= 1'b1;
    end else if (!ram_ce_n && !ram_we_n) begin
      sram[ram_addr[7:0]] <= ram_data;
    end
  end
  assign ram_data = (!ram_ce_n && !ram_oe_n) ? sram[ram_addr[7:0]] : 16'hzzzz;

  // Reference model: expected responses and timing at transaction level.
  typedef struct {
    int          kind;      // 0 read, 1 write, 2 fetch
    logic [15:0] addr;
    logic [15:0] data;
    int          done_cyc;
  } sb_item_t;

  sb_item_t    sb_q[$];
  logic [15:0] ref_mem [0:255];
  int          free_cyc = 0;
  bit          rbuf_ok = 1'b0;
  logic [15:0] rbuf_tag = '0;
  int          exp_bus = 0;

  int checks = 0, errors = 0;
  int done_cnt = 0, valid_cnt = 0, bus_cyc = 0, ce_run = 0, we_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [15:0] a, input logic [15:0] d,
                      input int req, output bit hit);
    sb_item_t e;
    int acc = (req > free_cyc) ? req : free_cyc;
    hit = 1'b0;
    e.kind = kind;
    e.addr = a;
    if (kind == 1) begin
      ref_mem[a[7:0]] = d;
      e.data = d;
      if (rbuf_ok && rbuf_tag == a) rbuf_ok = 1'b0;
    end else begin
      e.data = ref_mem[a[7:0]];
      if (kind == 2) begin
        hit = BUF_EN && rbuf_ok && (rbuf_tag == a);
        rbuf_ok  = 1'b1;
        rbuf_tag = a;
      end
    end
    e.done_cyc = acc + (hit ? 1 : LAT);
    free_cyc   = hit ? acc + 1 : e.done_cyc + 1;
    if (!hit) exp_bus += WAIT_CYC + 1;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input bit is_fetch);
    sb_item_t e;
    if (sb_q.size() == 0) begin
      check(is_fetch ? "sb_unexpected_inst_valid" : "sb_unexpected_mem_done", sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      check("resp_kind", is_fetch, e.kind == 2);
      check("resp_latency", cyc, e.done_cyc);
      case (e.kind)
        0: check("mem_rdata", mem_rdata, e.data);
        1: begin
          check("wdata_hold", ram_data, e.data);
          check("sram_written", sram[e.addr[7:0]], e.data);
        end
        default: check("inst", inst, e.data);
      endcase
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        ce_run = 0;
        we_run = 0;
      end else begin
        if (!ram_ce_n) begin
          ce_run++;
          bus_cyc++;
          if (!ram_we_n) we_run++;
          check("oe_we_exclusive", ram_oe_n | ram_we_n, 1);
        end else if (ce_run != 0) begin
          check("bus_access_len", ce_run, WAIT_CYC + 1);
          if (we_run != 0) check("we_low_len", we_run, ce_run);
          ce_run = 0;
          we_run = 0;
        end
        if (mem_done) begin
          done_cnt++;
          sb_pop(1'b0);
        end
        if (inst_valid) begin
          valid_cnt++;
          sb_pop(1'b1);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input bit fetch, input int start);
    int n = 0;
    while (((fetch ? valid_cnt : done_cnt) == start) && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check(fetch ? "wait_inst_valid" : "wait_mem_done", fetch ? valid_cnt : done_cnt, start + 1);
  endtask

  task automatic data_op(input bit we, input logic [15:0] a, input logic [15:0] d);
    int start = done_cnt;
    bit hit;
    push(we ? 1 : 0, a, d, cyc, hit);
    mem_op = 1'b1; mem_we = we; mem_addr = a; mem_wdata = d;
    wait_cnt(1'b0, start);
    mem_op = 1'b0; mem_we = 1'b0;
  endtask

  task automatic fetch_op(input logic [15:0] a);
    int start = valid_cnt;
    int b0 = bus_cyc;
    bit hit;
    push(2, a, 16'h0, cyc, hit);
    if_req = 1'b1; if_addr = a;
    tick();
    if_req = 1'b0;
    wait_cnt(1'b1, start);
    check("fetch_bus_cycles", bus_cyc - b0, hit ? 0 : WAIT_CYC + 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sd, sv, k;
    bit hit;
    logic [15:0] a;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    fork
      monitor();
    join_none

    // Reset state.
    repeat (3) tick();
    check("rst_ce_n", ram_ce_n, 1);
    check("rst_oe_n", ram_oe_n, 1);
    check("rst_we_n", ram_we_n, 1);
    check("rst_ram_data_z", ram_data, 16'hFFFF);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_mem_done", mem_done, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    check("rst_inst", inst, 16'h0800);
    rst = 1'b1;
    tick();

    // Reset during a write access aborts it without a completion pulse.
    mem_op = 1'b1; mem_we = 1'b1; mem_addr = 16'h007F; mem_wdata = 16'hBEEF;
    tick();
    check("abort_in_d_acc_we_n", ram_we_n, 0);
    rst = 1'b0; mem_op = 1'b0; mem_we = 1'b0;
    tick();
    check("abort_we_n", ram_we_n, 1);
    check("abort_ce_n", ram_ce_n, 1);
    check("abort_ram_data_z", ram_data, 16'hFFFF);
    check("abort_inst", inst, 16'h0800);
    check("abort_no_done", done_cnt, 0);
    rst = 1'b1;
    free_cyc = 0;
    rbuf_ok = 1'b0;
    repeat (2) tick();

    // Directed read, write, read-back.
    data_op(1'b0, 16'h0040, 16'h0);
    data_op(1'b1, 16'h0041, 16'hBEEF);
    tick();
    data_op(1'b0, 16'h0041, 16'h0);

    // Data and fetch requested together: data first.
    sd = done_cnt; sv = valid_cnt;
    push(0, 16'h0041, 16'h0, cyc, hit);
    push(2, 16'h0020, 16'h0, cyc, hit);
    mem_op = 1'b1; mem_we = 1'b0; mem_addr = 16'h0041;
    if_req = 1'b1; if_addr = 16'h0020;
    wait_cnt(1'b0, sd);
    mem_op = 1'b0;
    wait_cnt(1'b1, sv);
    if_req = 1'b0;
    tick();

    // mem_op arriving during a fetch waits for the fetch to finish.
    sd = done_cnt; sv = valid_cnt;
    push(2, 16'h0021, 16'h0, cyc, hit);
    if_req = 1'b1; if_addr = 16'h0021;
    tick();
    if_req = 1'b0;
    push(1, 16'h0042, 16'h55AA, cyc, hit);
    mem_op = 1'b1; mem_we = 1'b1; mem_addr = 16'h0042; mem_wdata = 16'h55AA;
    wait_cnt(1'b0, sd);
    mem_op = 1'b0; mem_we = 1'b0;
    check("fetch_before_data", valid_cnt, sv + 1);
    tick();

    // Back-to-back: mem_op held past mem_done with a new request.
    sd = done_cnt;
    push(0, 16'h0040, 16'h0, cyc, hit);
    mem_op = 1'b1; mem_we = 1'b0; mem_addr = 16'h0040;
    wait_cnt(1'b0, sd);
    sd = done_cnt;
    push(1, 16'h0043, 16'hC0DE, cyc, hit);
    mem_we = 1'b1; mem_addr = 16'h0043; mem_wdata = 16'hC0DE;
    wait_cnt(1'b0, sd);
    mem_op = 1'b0; mem_we = 1'b0;
    tick();

    // Repeated fetch, invalidating write, refetch.
    fetch_op(16'h0010);
    fetch_op(16'h0010);
    data_op(1'b1, 16'h0010, 16'h9A9A);
    fetch_op(16'h0010);

    // Randomised mix over a small address window so hits and read-after-write occur.
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) tick();
      k = $urandom_range(0, 2);
      a = 16'h0010 + 16'($urandom_range(0, 7));
      if (k == 2) fetch_op(a);
      else data_op(k == 1, a, 16'($urandom));
    end

    repeat (6) tick();
    check("sb_drained", sb_q.size(), 0);
    check("bus_cycles_total", bus_cyc, exp_bus);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
